// File: rtl/mux_generic_1bit.sv
// -----------------------------------------------------------------------------
// mux_generic_1bit
//
// Purpose:
//   Parameterised INPUTS-to-1 single-bit multiplexer with a combinational
//   output and a registered copy. The registered copy carries a flag that
//   shows whether a capture has happened since reset. It serves as a generic
//   bit-select leaf in datapath and control steering logic.
//
// Parameters:
//   INPUTS  number of data inputs, 2..256, need not be a power of two
//   SEL_W   select width, $clog2(INPUTS) (derived, not overridable)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   w_in       in   [INPUTS-1:0] data inputs, bit i is candidate i
//   s_in       in   [SEL_W-1:0]  select index, unsigned
//   en_in      in   capture strobe for the registered output
//   f_out      out  combinational selected bit (0 when s_in >= INPUTS)
//   f_q        out  registered selected bit
//   f_q_valid  out  f_q holds a capture made since reset
//   sel_err    out  (MUX_SEL_ERR_EN only) s_in >= INPUTS
//
// Build option:
//   MUX_SEL_ERR_EN  When this macro is defined, the sel_err port is added.
//                   A capture taken while sel_err is high stores f_q = 0 and
//                   clears f_q_valid, which marks the sample as invalid.
//                   When the macro is undefined, an out-of-range capture
//                   stores 0 and sets f_q_valid.
// -----------------------------------------------------------------------------
module mux_generic_1bit #(
  parameter  int INPUTS = 4,
  localparam int SEL_W  = $clog2(INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] w_in,
  input  logic [SEL_W-1:0]  s_in,
  input  logic              en_in,
  output logic              f_out,
  output logic              f_q,
  output logic              f_q_valid
`ifdef MUX_SEL_ERR_EN
  ,
  output logic              sel_err
`endif
);

  // One-hot decode of the select. An out-of-range index matches no line, so
  // the OR-reduction below yields 0 without a separate range check. An X on
  // s_in makes the equality compares X, and that X reaches f_out.
  logic [INPUTS-1:0] sel_onehot;

  generate
    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_dec
      assign sel_onehot[gi] = (s_in == SEL_W'(gi));
    end
  endgenerate

  assign f_out = |(sel_onehot & w_in);

`ifdef MUX_SEL_ERR_EN
  // When INPUTS is a power of two, every select code is legal. In that case
  // sel_err is a constant 0 and drives no logic.
  localparam bit                IS_POW2    = (INPUTS == (1 << SEL_W));
  localparam logic [SEL_W:0]    INPUTS_EXT = (SEL_W + 1)'(INPUTS);

  logic sel_oor;

  assign sel_oor = ({1'b0, s_in} >= INPUTS_EXT);
  assign sel_err = IS_POW2 ? 1'b0 : sel_oor;
`endif

  // The registered copy is cleared immediately on reset. After reset it
  // changes only on an en_in-qualified edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q       <= 1'b0;
      f_q_valid <= 1'b0;
    end else if (en_in) begin
`ifdef MUX_SEL_ERR_EN
      if (sel_err) begin
        f_q       <= 1'b0;
        f_q_valid <= 1'b0;
      end else begin
        f_q       <= f_out;
        f_q_valid <= 1'b1;
      end
`else
      f_q       <= f_out;
      f_q_valid <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mux_generic_1bit.sv
// -----------------------------------------------------------------------------
// tb_mux_generic_1bit
//
// Two instances of the multiplexer share one clock, one reset and one capture
// strobe:
//   u4  INPUTS = 4 (power of two, every select code is legal)
//   u5  INPUTS = 5 (select codes 5..7 are out of range)
// Expected values come from a reference model that treats the data word as an
// integer and uses shifts to pick the bit. A pair of expected registers holds
// the captured state of each instance.
// -----------------------------------------------------------------------------
module tb_mux_generic_1bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_in;
  logic [3:0] w4;
  logic [1:0] s4;
  logic [4:0] w5;
  logic [2:0] s5;
  logic       f4, q4, v4;
  logic       f5, q5, v5;
`ifdef MUX_SEL_ERR_EN
  logic       e4, e5;
`endif

  int checks = 0;
  int errors = 0;

  // Expected registered state of each instance
  logic eq4, ev4, eq5, ev5;

  always #5 clk = ~clk;

  mux_generic_1bit #(.INPUTS(4)) u4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_in     (w4),
    .s_in     (s4),
    .en_in    (en_in),
    .f_out    (f4),
    .f_q      (q4),
    .f_q_valid(v4)
`ifdef MUX_SEL_ERR_EN
    ,
    .sel_err  (e4)
`endif
  );

  mux_generic_1bit #(.INPUTS(5)) u5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_in     (w5),
    .s_in     (s5),
    .en_in    (en_in),
    .f_out    (f5),
    .f_q      (q5),
    .f_q_valid(v5)
`ifdef MUX_SEL_ERR_EN
    ,
    .sel_err  (e5)
`endif
  );

  // Reference model: the selected bit, or 0 when the index is out of range
  function automatic logic mdl_sel(input int n, input int w, input int s);
    if (s >= n) return 1'b0;
    return 1'((w >> s) & 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, "_f4"}, 32'(f4), 32'(mdl_sel(4, int'(w4), int'(s4))));
    chk({tag, "_f5"}, 32'(f5), 32'(mdl_sel(5, int'(w5), int'(s5))));
`ifdef MUX_SEL_ERR_EN
    chk({tag, "_e4"}, 32'(e4), 32'd0);
    chk({tag, "_e5"}, 32'(e5), 32'(int'(s5) >= 5));
`endif
  endtask

  task automatic chk_reg(input string tag);
    chk({tag, "_q4"}, 32'(q4), 32'(eq4));
    chk({tag, "_v4"}, 32'(v4), 32'(ev4));
    chk({tag, "_q5"}, 32'(q5), 32'(eq5));
    chk({tag, "_v5"}, 32'(v5), 32'(ev5));
  endtask

  // Advance one clock. The expected state uses the input values that are
  // present before the edge. The registered outputs are checked 1 ns after
  // the edge.
  task automatic step(input string tag);
    if (!rst_n) begin
      eq4 = 1'b0; ev4 = 1'b0; eq5 = 1'b0; ev5 = 1'b0;
    end else if (en_in) begin
      eq4 = mdl_sel(4, int'(w4), int'(s4));
      ev4 = 1'b1;
`ifdef MUX_SEL_ERR_EN
      if (int'(s5) >= 5) begin
        eq5 = 1'b0; ev5 = 1'b0;
      end else begin
        eq5 = mdl_sel(5, int'(w5), int'(s5)); ev5 = 1'b1;
      end
`else
      eq5 = mdl_sel(5, int'(w5), int'(s5));
      ev5 = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    $display("txn %s rst_n=%b en=%b w4=%b s4=%0d w5=%b s5=%0d -> q4=%b v4=%b q5=%b v5=%b",
             tag, rst_n, en_in, w4, s4, w5, s5, q4, v4, q5, v5);
    chk_reg(tag);
  endtask

  // Directed combinational sequence: the selected bit is isolated from the others
  task automatic comb_seq(input logic [1:0] s, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c);
    s4 = s;
    w4 = a; #5; chk("t1_a", 32'(f4), 32'd0);
    w4 = b; #5; chk("t1_b", 32'(f4), 32'd1);
    w4 = c; #5; chk("t1_c", 32'(f4), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en_in = 1'b1;
    w4 = 4'b1111; s4 = 2'd0; w5 = 5'b11111; s5 = 3'd0;
    eq4 = 1'b0; ev4 = 1'b0; eq5 = 1'b0; ev5 = 1'b0;

    // Held in reset with the clock running and en_in high
    repeat (3) step("rst_hold");
    chk("rst_f4", 32'(f4), 32'd1);

    // Combinational path under reset, with 5 ns steps
    comb_seq(2'd0, 4'b0000, 4'b0001, 4'b1110);
    comb_seq(2'd1, 4'b0000, 4'b0010, 4'b1101);
    comb_seq(2'd2, 4'b0000, 4'b0100, 4'b1011);
    comb_seq(2'd3, 4'b0000, 4'b1000, 4'b0111);

    // Capture, then hold
    @(posedge clk); #1;
    rst_n = 1'b1; w4 = 4'b0100; s4 = 2'd2; en_in = 1'b1; w5 = 5'b00100; s5 = 3'd2;
    step("cap");
    chk("cap_q4", 32'(q4), 32'd1);
    en_in = 1'b0; w4 = 4'b0000; w5 = 5'b00000;
    step("hold");
    chk("hold_f4", 32'(f4), 32'd0);
    chk("hold_q4", 32'(q4), 32'd1);

    // Asynchronous reset asserted between clock edges
    #2; rst_n = 1'b0; #1;
    eq4 = 1'b0; ev4 = 1'b0; eq5 = 1'b0; ev5 = 1'b0;
    chk_reg("async_rst");
    step("async_rst_low");
    rst_n = 1'b1;

    // Out-of-range selects on the INPUTS=5 instance
    w5 = 5'b10000; s5 = 3'd4; #1; chk("t4_s4", 32'(f5), 32'd1);
    w5 = 5'b11111;
    for (int s = 5; s < 8; s++) begin
      s5 = 3'(s); #1; chk_comb("t4_oor");
    end
    en_in = 1'b1; s5 = 3'd6;
    step("oor_cap");
    s5 = 3'd3; #1; chk_comb("t5_inrange");
    step("inrange_cap");

    // Exhaustive sweep on the INPUTS=4 instance, with a capture for each combination
    en_in = 1'b1;
    for (int w = 0; w < 16; w++) begin
      for (int s = 0; s < 4; s++) begin
        w4 = 4'(w); s4 = 2'(s); #1;
        chk("sweep_f4", 32'(f4), 32'(mdl_sel(4, w, s)));
        step("sweep");
      end
    end

    // Randomised traffic: occasional asynchronous resets and a random strobe
    for (int i = 0; i < 300; i++) begin
      w4 = 4'($urandom); s4 = 2'($urandom);
      w5 = 5'($urandom); s5 = 3'($urandom);
      en_in = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        eq4 = 1'b0; ev4 = 1'b0; eq5 = 1'b0; ev5 = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      #1;
      chk_comb("rand");
      if (!rst_n) chk_reg("rand_rst");
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
